// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Producer-side hazard controller for the 5-stage pipeline. Covers the
// hazards that forwarding cannot: load-use stalls, multi-cycle data-memory
// waits and branch-taken flushes. It also owns the data-memory req/ack
// handshake and a sticky timeout error.
//
// Priority every cycle: memory freeze > branch flush > load-use stall.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   IF_ID_Rs1/Rs2              source registers of the instruction in decode
//   IF_ID_uses_rs1/rs2         decode actually reads that source
//   ID_EX_Rd, ID_EX_MemRead    destination / is-load of the instruction in EX
//   EX_MEM_mem_op              instruction in MEM performs a load or store
//   EX_MEM_branch_taken        branch/jump resolved taken in MEM
//   mem_ack                    data memory completed the current request
//   mem_req                    data-memory request
//   pc_write .. MEM_WB_write   pipeline-register write enables
//   IF_ID/ID_EX/EX_MEM_flush   insert a bubble into that register
//   mem_err                    sticky memory-timeout error (state ERROR)
//   stall_cnt, flush_cnt       saturating performance counters
//
// Configuration
//   HAZARD_PERF_CNT_EN  when defined, adds stall_cnt/flush_cnt and their ports.
// -----------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 16,  // max MEM_WAIT cycles before ERROR, >= 2
  parameter int CNT_W       = 16   // performance counter width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic             IF_ID_uses_rs1,
  input  logic             IF_ID_uses_rs2,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_MemRead,
  input  logic             EX_MEM_mem_op,
  input  logic             EX_MEM_branch_taken,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              load_use;
  logic              branch_flush;

  // Memory not ready (or dead): hold every pipeline register in place.
  assign freeze = ((state == RUN) && EX_MEM_mem_op && !mem_ack) ||
                  ((state == MEM_WAIT) && !mem_ack) ||
                  (state == ERROR);

  // Register 0 is hard-wired zero, so a load targeting it creates no hazard.
  assign load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                    (((ID_EX_Rd == IF_ID_Rs1) && IF_ID_uses_rs1) ||
                     ((ID_EX_Rd == IF_ID_Rs2) && IF_ID_uses_rs2));

  assign branch_flush = EX_MEM_branch_taken && !freeze;

  // Qualified by rst_n so an in-flight request drops the instant reset is
  // asserted, even while the memory-stage instruction still shows mem_op.
  assign mem_req = rst_n && (((state == RUN) && EX_MEM_mem_op) ||
                             (state == MEM_WAIT));

  assign mem_err = (state == ERROR);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_write  = 1'b1;
    EX_MEM_write = 1'b1;
    MEM_WB_write = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    next_state   = state;

    if (freeze) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
    end else if (EX_MEM_branch_taken) begin
      // Wrong-path instructions in IF/ID, ID/EX and EX/MEM are squashed;
      // any load-use on the wrong path is irrelevant.
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and decode one cycle, push a bubble into execute.
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
    end

    unique case (state)
      RUN:      if (EX_MEM_mem_op && !mem_ack) next_state = MEM_WAIT;
      MEM_WAIT: begin
        if (mem_ack)                    next_state = RUN;
        else if (wait_cnt == WAIT_LAST) next_state = ERROR;
      end
      ERROR:    next_state = ERROR;  // left only by reset
      default:  next_state = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      // Held at zero outside MEM_WAIT, which clears it on entry.
      if (state != MEM_WAIT)   wait_cnt <= '0;
      else if (wait_cnt != '1) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_event;
  assign stall_event = freeze || (load_use && !EX_MEM_branch_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_event && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Directed checks of hazard_control_unit (MEM_TIMEOUT = 4): reset state,
// load-use stall, zero-wait and 3-cycle-late memory, branch priority over
// load-use and over a pending wait, timeout into ERROR, and asynchronous
// reset during a wait.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
  logic IF_ID_uses_rs1, IF_ID_uses_rs2, ID_EX_MemRead;
  logic EX_MEM_mem_op, EX_MEM_branch_taken, mem_ack;
  logic mem_req, pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
  logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [CNT_W-1:0] stall_snap, flush_snap;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .IF_ID_Rs1           (IF_ID_Rs1),
    .IF_ID_Rs2           (IF_ID_Rs2),
    .IF_ID_uses_rs1      (IF_ID_uses_rs1),
    .IF_ID_uses_rs2      (IF_ID_uses_rs2),
    .ID_EX_Rd            (ID_EX_Rd),
    .ID_EX_MemRead       (ID_EX_MemRead),
    .EX_MEM_mem_op       (EX_MEM_mem_op),
    .EX_MEM_branch_taken (EX_MEM_branch_taken),
    .mem_ack             (mem_ack),
    .mem_req             (mem_req),
    .pc_write            (pc_write),
    .IF_ID_write         (IF_ID_write),
    .ID_EX_write         (ID_EX_write),
    .EX_MEM_write        (EX_MEM_write),
    .MEM_WB_write        (MEM_WB_write),
    .IF_ID_flush         (IF_ID_flush),
    .ID_EX_flush         (ID_EX_flush),
    .EX_MEM_flush        (EX_MEM_flush),
    .mem_err             (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt           (stall_cnt),
    .flush_cnt           (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Enables packed {pc, IF_ID, ID_EX, EX_MEM, MEM_WB}; flushes {IF_ID, ID_EX, EX_MEM}.
  logic [4:0] wen;
  logic [2:0] fl;
  assign wen = {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write};
  assign fl  = {IF_ID_flush, ID_EX_flush, EX_MEM_flush};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    IF_ID_Rs1 = 5'd0; IF_ID_Rs2 = 5'd0;
    IF_ID_uses_rs1 = 1'b0; IF_ID_uses_rs2 = 1'b0;
    ID_EX_Rd = 5'd0; ID_EX_MemRead = 1'b0;
    EX_MEM_mem_op = 1'b0; EX_MEM_branch_taken = 1'b0; mem_ack = 1'b0;
  endtask

  // Advance one clock; inputs then change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    // ---- reset state ----
    check("rst_mem_req", mem_req, 0);
    check("rst_wen", wen, 5'b11111);
    check("rst_flush", fl, 3'b000);
    check("rst_mem_err", mem_err, 0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // ---- load-use on rs2 ----
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd5; IF_ID_Rs2 = 5'd5; IF_ID_uses_rs2 = 1'b1;
    #1;
    check("lu_wen", wen, 5'b00111);
    check("lu_flush", fl, 3'b010);
    tick();
    ID_EX_MemRead = 1'b0;  // bubble now in execute
    #1;
    check("lu_next_wen", wen, 5'b11111);
    check("lu_next_flush", fl, 3'b000);
    // Rd = 0 never stalls
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd0; IF_ID_Rs2 = 5'd0;
    #1;
    check("lu_rd0_wen", wen, 5'b11111);
    // rs1 matches but decode does not read it
    ID_EX_Rd = 5'd7; IF_ID_Rs1 = 5'd7; IF_ID_uses_rs1 = 1'b0; IF_ID_uses_rs2 = 1'b0;
    #1;
    check("lu_unused_wen", wen, 5'b11111);
    IF_ID_uses_rs1 = 1'b1;
    #1;
    check("lu_rs1_wen", wen, 5'b00111);
    tick();
    idle();

    // ---- zero-wait memory ----
    EX_MEM_mem_op = 1'b1; mem_ack = 1'b1;
    #1;
    check("zw_mem_req", mem_req, 1);
    check("zw_wen", wen, 5'b11111);
    tick();
    idle();
    #1;
    check("zw_stay_run_req", mem_req, 0);  // MEM_WAIT would keep req high
    check("zw_stay_run_wen", wen, 5'b11111);

    // ---- wait state, ack three cycles late ----
`ifdef HAZARD_PERF_CNT_EN
    stall_snap = stall_cnt;
`endif
    EX_MEM_mem_op = 1'b1; mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("ws_wen_c%0d", c), wen, 5'b00000);
      check($sformatf("ws_req_c%0d", c), mem_req, 1);
      tick();
    end
    mem_ack = 1'b1;
    #1;
    check("ws_ack_wen", wen, 5'b11111);
    check("ws_ack_req", mem_req, 1);
    tick();
    idle();
    #1;
    check("ws_after_req", mem_req, 0);
`ifdef HAZARD_PERF_CNT_EN
    check("ws_stall_cnt", stall_cnt - stall_snap, 3);
`endif

    // ---- branch beats load-use ----
`ifdef HAZARD_PERF_CNT_EN
    flush_snap = flush_cnt;
`endif
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd9; IF_ID_Rs1 = 5'd9; IF_ID_uses_rs1 = 1'b1;
    EX_MEM_branch_taken = 1'b1;
    #1;
    check("br_lu_flush", fl, 3'b111);
    check("br_lu_wen", wen, 5'b11111);
    tick();
    idle();
`ifdef HAZARD_PERF_CNT_EN
    #1;
    check("br_flush_cnt", flush_cnt - flush_snap, 1);
`endif

    // ---- branch held during a wait, flushes in ack cycle ----
    EX_MEM_mem_op = 1'b1; mem_ack = 1'b0;
    tick();
    EX_MEM_branch_taken = 1'b1;
    #1;
    check("brw_frozen_flush", fl, 3'b000);
    check("brw_frozen_wen", wen, 5'b00000);
    tick();
    mem_ack = 1'b1;
    #1;
    check("brw_ack_flush", fl, 3'b111);
    check("brw_ack_wen", wen, 5'b11111);
    tick();
    idle();

    // ---- timeout (MEM_TIMEOUT = 4): RUN cycle + 4 MEM_WAIT cycles ----
    EX_MEM_mem_op = 1'b1; mem_ack = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("to_before_err", mem_err, 0);
    check("to_before_req", mem_req, 1);
    tick();
    check("to_err", mem_err, 1);
    check("to_err_req", mem_req, 0);
    check("to_err_wen", wen, 5'b00000);
    EX_MEM_mem_op = 1'b0; mem_ack = 1'b1;  // ERROR is not left by ack
    tick();
    check("to_sticky_err", mem_err, 1);
    check("to_sticky_wen", wen, 5'b00000);
    idle();
    rst_n = 1'b0;
    #1;
    check("to_rst_err", mem_err, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("to_rst_wen", wen, 5'b11111);
    check("to_rst_req", mem_req, 0);

    // ---- async reset mid-wait ----
    tick();
    EX_MEM_mem_op = 1'b1; mem_ack = 1'b0;
    tick();
    tick();
    check("ar_wait_req", mem_req, 1);
    #2;
    rst_n = 1'b0;  // between edges
    #1;
    check("ar_req_drop", mem_req, 0);
    idle();
    tick();
    rst_n = 1'b1;
    #1;
    check("ar_after_wen", wen, 5'b11111);
    check("ar_after_err", mem_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
